// File: rtl/fed_arbiter.sv
// fed_arbiter: two-requester arbiter and sequencer for the shared FFT/ENC/DEC unit.
// Optional macro FED_ARB_RR_EN selects round-robin tie-breaking; otherwise requester 0 has fixed priority.
module fed_arbiter #(
    parameter int DW      = 19,
    parameter int FFT_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [2:0]    req0_op,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [2:0]    fed_op,
    output logic [DW-1:0] fed_din,
    input  logic [DW-1:0] fed_dout,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    input  logic          rsp_ready,
    output logic          busy
);
    localparam logic [2:0] OP_FFT   = 3'b001;
    localparam logic [3:0] LAT_LOAD = 4'(FFT_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_op;
    logic [DW-1:0] r_data;
    logic          r_id;
    logic [3:0]    r_cnt;
    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_data;

    logic          w_tie_pick1;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_accept;
    logic          w_exec_done;
    logic          w_rsp_done;
    logic [2:0]    w_sel_op;

`ifdef FED_ARB_RR_EN
    logic r_last;

    // On a tie, grant whichever requester did not win the previous handshake.
    assign w_tie_pick1 = ~r_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant1;
        end
    end
`else
    assign w_tie_pick1 = 1'b0;
`endif

    assign w_grant1    = req1_valid & (~req0_valid | w_tie_pick1);
    assign w_grant0    = req0_valid & ~w_grant1;
    assign req0_ready  = (r_state == S_IDLE) & w_grant0 & rst;
    assign req1_ready  = (r_state == S_IDLE) & w_grant1 & rst;
    assign w_accept    = req0_ready | req1_ready;
    assign w_sel_op    = w_grant1 ? req1_op : req0_op;
    assign w_exec_done = (r_state == S_EXEC) && (r_cnt == 4'd0);
    assign w_rsp_done  = (r_state == S_RESP) && r_rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_next = S_EXEC;
            S_EXEC:  if (w_exec_done) w_state_next = S_RESP;
            S_RESP:  if (w_rsp_done)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op        <= 3'b000;
            r_data      <= '0;
            r_id        <= 1'b0;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= w_sel_op;
                r_data <= w_grant1 ? req1_data : req0_data;
                r_id   <= w_grant1;
                r_cnt  <= (w_sel_op == OP_FFT) ? LAT_LOAD : 4'd0;
            end
            // The counter reaching zero marks the cycle whose fed_dout is the valid result.
            if (r_state == S_EXEC) begin
                if (r_cnt == 4'd0) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_data  <= fed_dout;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign fed_op    = (r_state == S_EXEC) ? r_op : 3'b000;
    assign fed_din   = (r_state == S_EXEC) ? r_data : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fed_arbiter.sv
// tb_fed_arbiter: randomized self-checking bench for fed_arbiter with a behavioural FED unit and transaction model.
// Honours FED_ARB_RR_EN to select the expected tie-breaking policy.
module tb_fed_arbiter;
    localparam int DW      = 19;
    localparam int FFT_LAT = 4;
`ifdef FED_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0;
    logic [2:0]    req0_op = 3'b000;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [2:0]    req1_op = 3'b000;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic [2:0]    fed_op;
    logic [DW-1:0] fed_din;
    logic [DW-1:0] fed_dout;
    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_ready = 1'b0;
    logic          busy;

    int   checks = 0;
    int   failures = 0;
    logic model_last = 1'b1;

    always #5 clk = ~clk;

    fed_arbiter #(.DW(DW), .FFT_LAT(FFT_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
        .fed_op(fed_op), .fed_din(fed_din), .fed_dout(fed_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    // FED unit: ENC/DEC are combinational; FFT output is garbage until the input has been stable FFT_LAT cycles.
    function automatic logic [DW-1:0] unit_fn(input logic [2:0] op, input logic [DW-1:0] d);
        case (op)
            3'b100:  return d ^ 19'h003FF;
            3'b010:  return {d[0], d[DW-1:1]} ^ 19'h2A5A5;
            3'b001:  return d + 19'h01234;
            default: return '0;
        endcase
    endfunction

    logic [4:0] fft_cnt = 5'd0;
    always @(posedge clk) begin
        if (fed_op == 3'b001) fft_cnt <= (fft_cnt == 5'd31) ? fft_cnt : fft_cnt + 5'd1;
        else                  fft_cnt <= 5'd0;
    end
    assign fed_dout = (fed_op == 3'b001 && fft_cnt < FFT_LAT) ? 19'h55555 : unit_fn(fed_op, fed_din);

    function automatic logic tie_winner(input logic last);
        return RR_EN ? ~last : 1'b0;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 3'b100; req1_op = 3'b100;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, fed_op, fed_din, busy, req0_ready, req1_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rsp_valid=%b rsp_id=%b rsp_data=%h fed_op=%b fed_din=%h busy=%b rdy=%b%b required all zero",
                     rsp_valid, rsp_id, rsp_data, fed_op, fed_din, busy, req0_ready, req1_ready);
        end
        $display("reset: outputs rsp_valid=%b busy=%b ready=%b%b", rsp_valid, busy, req0_ready, req1_ready);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_single_ops();
        logic          v0, v1, win;
        logic [2:0]    op0, op1, op;
        logic [DW-1:0] d0, d1, d, exp_d;
        int            lat;
        do_reset();
        for (int t = 0; t < 24; t++) begin
            v0 = 1'b0; v1 = 1'b0; op0 = 3'b000; op1 = 3'b000; d0 = '0; d1 = '0;
            case (t)
                0: begin v0 = 1'b1; op0 = 3'b100; d0 = 19'h00000; end
                1: begin v1 = 1'b1; op1 = 3'b001; d1 = DW'($urandom); end
                2: begin v0 = 1'b1; op0 = 3'b111; d0 = 19'h12345; end
                3: begin v1 = 1'b1; op1 = 3'b010; d1 = DW'($urandom); end
                default: begin
                    v0 = 1'($urandom); v1 = 1'($urandom);
                    if (!v0 && !v1) v0 = 1'b1;
                    op0 = 3'($urandom_range(0, 7)); op1 = 3'($urandom_range(0, 7));
                    d0 = DW'($urandom); d1 = DW'($urandom);
                end
            endcase
            win = (v0 && v1) ? tie_winner(model_last) : v1;
            op  = win ? op1 : op0;
            d   = win ? d1 : d0;
            lat = (op == 3'b001) ? FFT_LAT + 1 : 1;
            exp_d = unit_fn(op, d);
            @(posedge clk); #1;
            req0_valid = v0; req0_op = op0; req0_data = d0;
            req1_valid = v1; req1_op = op1; req1_data = d1;
            rsp_ready = 1'b1;
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready} !== {~win, win}) begin
                failures++;
                $display("FAIL grant_t%0d: ready=%b%b required=%b%b", t, req0_ready, req1_ready, ~win, win);
            end
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            model_last = win;
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                checks++;
                if ({fed_op, fed_din, busy, rsp_valid} !== {op, d, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL exec_t%0d_c%0d: fed_op=%b fed_din=%h busy=%b rsp_valid=%b required fed_op=%b fed_din=%h busy=1 rsp_valid=0",
                             t, i, fed_op, fed_din, busy, rsp_valid, op, d);
                end
            end
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, fed_op, fed_din} !== {1'b1, win, exp_d, 3'b000, {DW{1'b0}}}) begin
                failures++;
                $display("FAIL resp_t%0d: rsp_valid=%b rsp_id=%b rsp_data=%h fed_op=%b fed_din=%h required 1 %b %h 000 0",
                         t, rsp_valid, rsp_id, rsp_data, fed_op, fed_din, win, exp_d);
            end
            @(negedge clk);
            checks++;
            if ({busy, rsp_valid, rsp_id, rsp_data} !== {1'b0, 1'b0, win, exp_d}) begin
                failures++;
                $display("FAIL idle_t%0d: busy=%b rsp_valid=%b rsp_id=%b rsp_data=%h required 0 0 %b %h",
                         t, busy, rsp_valid, rsp_id, rsp_data, win, exp_d);
            end
            $display("op t=%0d id=%0d op=%b din=%h rsp=%h", t, win, op, d, rsp_data);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back_tie();
        logic [DW-1:0] d0, d1, exp_d;
        logic          exp_order[4];
        logic          got_order[4];
        int            grant_cyc[4];
        int            grants, resps, cyc;
        do_reset();
        d0 = DW'($urandom); d1 = DW'($urandom);
        for (int i = 0; i < 4; i++) exp_order[i] = RR_EN ? 1'(i % 2) : 1'b0;
        grants = 0; resps = 0; cyc = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 3'b010; req0_data = d0;
        req1_valid = 1'b1; req1_op = 3'b010; req1_data = d1;
        rsp_ready = 1'b1;
        while (resps < 4 && cyc < 60) begin
            @(negedge clk);
            if (req0_ready && req1_ready) begin
                checks++; failures++;
                $display("FAIL tie_both_ready: cycle=%0d ready=11 required at most one", cyc);
            end
            if ((req0_ready || req1_ready) && grants < 4) begin
                got_order[grants] = req1_ready;
                grant_cyc[grants] = cyc;
                grants++;
            end
            if (rsp_valid && resps < 4) begin
                exp_d = unit_fn(3'b010, exp_order[resps] ? d1 : d0);
                checks++;
                if ({rsp_id, rsp_data} !== {exp_order[resps], exp_d}) begin
                    failures++;
                    $display("FAIL tie_resp%0d: rsp_id=%b rsp_data=%h required %b %h", resps, rsp_id, rsp_data, exp_order[resps], exp_d);
                end
                resps++;
            end
            @(posedge clk); #1;
            if (grants == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            cyc++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (grants != 4 || resps != 4) begin
            failures++;
            $display("FAIL tie_timeout: grants=%0d resps=%0d required 4 4 within 60 cycles", grants, resps);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_order[i] !== exp_order[i]) begin
                    failures++;
                    $display("FAIL tie_order%0d: granted=%0d required=%0d", i, got_order[i], exp_order[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (grant_cyc[i] - grant_cyc[i-1] != 3) begin
                        failures++;
                        $display("FAIL tie_interval%0d: interval=%0d required=3", i, grant_cyc[i] - grant_cyc[i-1]);
                    end
                end
                $display("tie grant %0d -> requester %0d at cycle %0d", i, got_order[i], grant_cyc[i]);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d, exp_d;
        do_reset();
        d = DW'($urandom);
        exp_d = unit_fn(3'b100, d);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_op = 3'b100; req1_data = d; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 0) begin req0_valid = 1'b1; req0_op = 3'b010; req1_valid = 1'b1; end
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, fed_op, fed_din, busy, req0_ready, req1_ready} !==
                {1'b1, 1'b1, exp_d, 3'b000, {DW{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d: rsp_valid=%b rsp_id=%b rsp_data=%h fed_op=%b busy=%b rdy=%b%b required 1 1 %h 000 1 00",
                         i, rsp_valid, rsp_id, rsp_data, fed_op, busy, req0_ready, req1_ready, exp_d);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid, rsp_id, rsp_data} !== {1'b0, 1'b0, 1'b1, exp_d}) begin
            failures++;
            $display("FAIL bp_release: busy=%b rsp_valid=%b rsp_id=%b rsp_data=%h required 0 0 1 %h",
                     busy, rsp_valid, rsp_id, rsp_data, exp_d);
        end
        $display("backpressure: held 11 cycles, released rsp_data=%h", rsp_data);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fft();
        logic [DW-1:0] d, x;
        do_reset();
        d = DW'($urandom); x = DW'($urandom);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 3'b001; req0_data = d; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({fed_op, fed_din} !== {3'b001, d}) begin
            failures++;
            $display("FAIL midfft_exec3: fed_op=%b fed_din=%h required 001 %h", fed_op, fed_din, d);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, fed_op, fed_din, busy, req0_ready, req1_ready} !== '0) begin
            failures++;
            $display("FAIL midfft_reset: rsp_valid=%b rsp_id=%b rsp_data=%h fed_op=%b busy=%b required all zero",
                     rsp_valid, rsp_id, rsp_data, fed_op, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1; model_last = 1'b1;
        req1_valid = 1'b1; req1_op = 3'b100; req1_data = x;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL midfft_accept: req1_ready=%b required 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, fed_op, fed_din} !== {1'b0, 3'b100, x}) begin
            failures++;
            $display("FAIL midfft_newexec: rsp_valid=%b fed_op=%b fed_din=%h required 0 100 %h", rsp_valid, fed_op, fed_din, x);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, unit_fn(3'b100, x)}) begin
            failures++;
            $display("FAIL midfft_newresp: rsp_valid=%b rsp_id=%b rsp_data=%h required 1 1 %h",
                     rsp_valid, rsp_id, rsp_data, unit_fn(3'b100, x));
        end
        $display("reset mid-FFT: new ENC response rsp_data=%h", rsp_data);
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_back_to_back_tie();
        test_backpressure();
        test_reset_mid_fft();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
